// File: rtl/cpu_seq_fetch.sv
// Subcycle sequencer and one/two-word instruction fetch from a multiplexed ROM bus.
// Optional stall handshake enabled by defining CPU_SEQ_STALL_EN.
module cpu_seq_fetch #(
  parameter int unsigned              DATA_W        = 4,
  parameter int unsigned              CYCLES        = 8,
  parameter int unsigned              FETCH_HI      = 3,
  parameter int unsigned              FETCH_LO      = 4,
  parameter logic [(2**DATA_W)-1:0]   TWO_WORD_MASK = 16'h0034,
  parameter logic [DATA_W-1:0]        FIN_OPCODE    = 4'h3
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            data,
  input  logic                         stall,
  output logic                         sync,
  output logic [$clog2(CYCLES)-1:0]    cycle,
  output logic                         second_word,
  output logic [2*DATA_W-1:0]          inst,
  output logic [2*DATA_W-1:0]          operand,
  output logic                         inst_done
);

  localparam int unsigned CW = $clog2(CYCLES);
  localparam int unsigned IW = 2 * DATA_W;

  typedef enum logic {W0 = 1'b0, W1 = 1'b1} word_state_t;

  word_state_t       r_state;
  logic [CW-1:0]     r_cycle;
  logic [IW-1:0]     r_inst;
  logic [IW-1:0]     r_operand;

  logic              w_last;
  logic              w_stall;
  logic              w_advance;
  logic              w_two_word;
  logic [DATA_W-1:0] w_opcode;

  assign w_last = (r_cycle == CW'(CYCLES - 1));

`ifdef CPU_SEQ_STALL_EN
  assign w_stall = stall;
`else
  // stall port kept for a stable interface but has no effect
  assign w_stall = 1'b0 & stall;
`endif

  assign w_advance  = w_last & ~w_stall;
  assign w_opcode   = r_inst[IW-1 -: DATA_W];
  assign w_two_word = TWO_WORD_MASK[w_opcode] | ((w_opcode == FIN_OPCODE) & ~r_inst[0]);

  // Counter, word-phase FSM and the two half-word latches
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= W0;
      r_cycle   <= '0;
      r_inst    <= '0;
      r_operand <= '0;
    end else begin
      if (!(w_last && w_stall)) begin
        r_cycle <= w_last ? '0 : r_cycle + CW'(1);
      end
      if (r_cycle == CW'(FETCH_HI)) begin
        if (r_state == W1) r_operand[IW-1 -: DATA_W] <= data;
        else               r_inst[IW-1 -: DATA_W]    <= data;
      end
      if (r_cycle == CW'(FETCH_LO)) begin
        if (r_state == W1) r_operand[DATA_W-1:0] <= data;
        else               r_inst[DATA_W-1:0]    <= data;
      end
      if (w_advance) begin
        case (r_state)
          W0:      r_state <= w_two_word ? W1 : W0;
          W1:      r_state <= W0;
          default: r_state <= W0;
        endcase
      end
    end
  end

  assign cycle       = r_cycle;
  assign inst        = r_inst;
  assign operand     = r_operand;
  assign second_word = (r_state == W1);
  assign sync        = ~w_last;
  assign inst_done   = w_advance & ((r_state == W1) | ~w_two_word);

endmodule
